// File: rtl/sw_irq_ctrl_if.sv
// -----------------------------------------------------------------------------
// sw_irq_ctrl_if
// System-bus slave port bundle for the switch interrupt controller.
//   addr_i : byte address of the access (offset within the peripheral)
//   req_i  : access request
//   WE_i   : 1 = write, 0 = read
//   WD_i   : write data
//   RD_o   : registered read data, returned by the slave
// The master modport drives the request side; the slave modport returns RD_o.
// -----------------------------------------------------------------------------
interface sw_irq_ctrl_if;
    logic [31:0] addr_i;
    logic        req_i;
    logic        WE_i;
    logic [31:0] WD_i;
    logic [31:0] RD_o;

    modport master (
        output addr_i,
        output req_i,
        output WE_i,
        output WD_i,
        input  RD_o
    );

    modport slave (
        input  addr_i,
        input  req_i,
        input  WE_i,
        input  WD_i,
        output RD_o
    );
endinterface

// File: rtl/sw_irq_ctrl.sv
// -----------------------------------------------------------------------------
// sw_irq_ctrl
// Bus-attached controller for the board switches. Synchronises and debounces
// the raw switch levels, exposes the debounced value, latches per-switch change
// events and raises a maskable level interrupt.
//
// Ports
//   clk_i     : system clock
//   rst_i     : asynchronous reset, active-low
//   bus       : system-bus slave (addr_i, req_i, WE_i, WD_i, RD_o)
//   sw_i      : raw asynchronous switch levels
//   int_o     : interrupt request (level, registered)
//   int_rst_i : interrupt acknowledge pulse, clears all pending events
//
// Register map (full 32-bit address compare)
//   0x00 VALUE RO   debounced switch value
//   0x04 MASK  RW   per-switch interrupt enable
//   0x08 PEND  W1C  per-switch change event
//   0x0C THR   RW   debounce threshold (cycles of stability minus one)
//   other          read 0, writes ignored
// -----------------------------------------------------------------------------
module sw_irq_ctrl #(
    parameter int          SW_W    = 16,
    parameter logic [15:0] DEB_RST = 16'd1000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    sw_irq_ctrl_if.slave     bus,
    input  logic [SW_W-1:0]  sw_i,
    output logic             int_o,
    input  logic             int_rst_i
);

    localparam logic [31:0] ADDR_VALUE = 32'h0000_0000;
    localparam logic [31:0] ADDR_MASK  = 32'h0000_0004;
    localparam logic [31:0] ADDR_PEND  = 32'h0000_0008;
    localparam logic [31:0] ADDR_THR   = 32'h0000_000C;

    // State
    logic [SW_W-1:0] s1_reg;
    logic [SW_W-1:0] s2_reg;
    logic [SW_W-1:0] raw_prev_reg;
    logic [SW_W-1:0] stable_reg;
    logic [15:0]     cnt_reg;
    logic [SW_W-1:0] pend_reg;
    logic [SW_W-1:0] mask_reg;
    logic [15:0]     thr_reg;
    logic [31:0]     rd_reg;
    logic            int_reg;

    // Next-state
    logic [SW_W-1:0] stable_next;
    logic [15:0]     cnt_next;
    logic [SW_W-1:0] set_bits;
    logic [SW_W-1:0] pend_next;
    logic [SW_W-1:0] mask_next;
    logic [15:0]     thr_next;
    logic [31:0]     rd_next;
    logic            int_next;

    // Bus decode
    logic wr_en;
    logic rd_en;
    logic wr_mask;
    logic wr_pend;
    logic wr_thr;

    assign wr_en   = bus.req_i &  bus.WE_i;
    assign rd_en   = bus.req_i & ~bus.WE_i;
    assign wr_mask = wr_en && (bus.addr_i == ADDR_MASK);
    assign wr_pend = wr_en && (bus.addr_i == ADDR_PEND);
    assign wr_thr  = wr_en && (bus.addr_i == ADDR_THR);

    // Upper write-data bits carry no register field.
    logic unused_wd;
    assign unused_wd = ^bus.WD_i[31:16];

    // Debounce: a single shared counter measures how long the synchronised
    // vector has been both steady and different from the debounced value.
    // Any movement, or a return to the debounced value, restarts the count.
    always_comb begin
        cnt_next    = cnt_reg;
        stable_next = stable_reg;
        set_bits    = '0;
        if (s2_reg != raw_prev_reg) begin
            cnt_next = '0;
        end else if (s2_reg == stable_reg) begin
            cnt_next = '0;
        end else if (cnt_reg == thr_reg) begin
            stable_next = s2_reg;
            set_bits    = stable_reg ^ s2_reg;
            cnt_next    = '0;
        end else begin
            cnt_next = cnt_reg + 16'd1;
        end
    end

    // Pending bits: a debounce event wins over a W1C clear, which wins over
    // the interrupt acknowledge (which clears everything else).
    genvar gi;
    generate
        for (gi = 0; gi < SW_W; gi++) begin : g_pend
            assign pend_next[gi] = set_bits[gi]
                                 | (pend_reg[gi]
                                    & ~(wr_pend & bus.WD_i[gi])
                                    & ~int_rst_i);
        end
    endgenerate

    assign mask_next = wr_mask ? bus.WD_i[SW_W-1:0] : mask_reg;
    assign thr_next  = wr_thr  ? bus.WD_i[15:0]     : thr_reg;

    // Interrupt follows the post-edge PEND/MASK so a mask or clear write
    // takes effect on int_o at the same edge.
    assign int_next = |(pend_next & mask_next);

    // Read mux samples the pre-edge register contents.
    always_comb begin
        rd_next = rd_reg;
        if (rd_en) begin
            case (bus.addr_i)
                ADDR_VALUE: rd_next = {{(32-SW_W){1'b0}}, stable_reg};
                ADDR_MASK:  rd_next = {{(32-SW_W){1'b0}}, mask_reg};
                ADDR_PEND:  rd_next = {{(32-SW_W){1'b0}}, pend_reg};
                ADDR_THR:   rd_next = {16'd0, thr_reg};
                default:    rd_next = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s1_reg       <= '0;
            s2_reg       <= '0;
            raw_prev_reg <= '0;
            stable_reg   <= '0;
            cnt_reg      <= '0;
            pend_reg     <= '0;
            mask_reg     <= '0;
            thr_reg      <= DEB_RST;
            rd_reg       <= '0;
            int_reg      <= 1'b0;
        end else begin
            s1_reg       <= sw_i;
            s2_reg       <= s1_reg;
            raw_prev_reg <= s2_reg;
            stable_reg   <= stable_next;
            cnt_reg      <= cnt_next;
            pend_reg     <= pend_next;
            mask_reg     <= mask_next;
            thr_reg      <= thr_next;
            rd_reg       <= rd_next;
            int_reg      <= int_next;
        end
    end

    assign bus.RD_o = rd_reg;
    assign int_o    = int_reg;

endmodule

// File: tb/tb_sw_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sw_irq_ctrl
// Directed bench for sw_irq_ctrl: reset values, debounce latency, glitch
// rejection, W1C/mask interaction, same-edge PEND precedence, unmapped
// addresses and asynchronous reset mid-debounce.
// -----------------------------------------------------------------------------
module tb_sw_irq_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] sw;
    logic        int_o;
    logic        int_rst;
    logic [31:0] rdata;

    int compared   = 0;
    int mismatched = 0;

    sw_irq_ctrl_if bus_if();

    sw_irq_ctrl #(
        .SW_W    (16),
        .DEB_RST (16'd1000)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_n),
        .bus       (bus_if),
        .sw_i      (sw),
        .int_o     (int_o),
        .int_rst_i (int_rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; return 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        bus_if.addr_i = addr;
        bus_if.WD_i   = data;
        bus_if.WE_i   = 1'b1;
        bus_if.req_i  = 1'b1;
        tick();
        bus_if.req_i  = 1'b0;
        bus_if.WE_i   = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        bus_if.addr_i = addr;
        bus_if.WE_i   = 1'b0;
        bus_if.req_i  = 1'b1;
        tick();
        data          = bus_if.RD_o;
        bus_if.req_i  = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        sw            = 16'h0000;
        int_rst       = 1'b0;
        bus_if.addr_i = 32'd0;
        bus_if.WD_i   = 32'd0;
        bus_if.WE_i   = 1'b0;
        bus_if.req_i  = 1'b0;

        // Reset state
        ticks(2);
        check("rst_rd", bus_if.RD_o, 32'd0);
        check("rst_int", {31'd0, int_o}, 32'd0);
        rst_n = 1'b1;
        tick();
        bus_read(32'h0C, rdata);
        check("rst_thr", rdata, 32'd1000);
        bus_read(32'h08, rdata);
        check("rst_pend", rdata, 32'd0);

        // Debounce latency with THR=3: stable updates at edge 6
        bus_write(32'h0C, 32'd3);
        bus_write(32'h04, 32'h0000_0001);
        sw = 16'h0001;
        ticks(6);                                  // edges 0..5
        check("lat_int_e5", {31'd0, int_o}, 32'd0);
        tick();                                    // edge 6
        check("lat_int_e6", {31'd0, int_o}, 32'd1);
        bus_read(32'h00, rdata);
        check("lat_value", rdata, 32'h0000_0001);
        bus_read(32'h08, rdata);
        check("lat_pend", rdata, 32'h0000_0001);

        // Clear PEND, then a 3-cycle glitch on bit 2 must be ignored
        bus_write(32'h08, 32'h0000_0001);
        check("w1c_int", {31'd0, int_o}, 32'd0);
        sw = 16'h0005;
        ticks(3);
        sw = 16'h0001;
        ticks(10);
        bus_read(32'h00, rdata);
        check("glitch_value", rdata, 32'h0000_0001);
        bus_read(32'h08, rdata);
        check("glitch_pend", rdata, 32'h0000_0000);
        check("glitch_int", {31'd0, int_o}, 32'd0);

        // PEND=5 with MASK=4, then W1C bit 2 and re-mask to bit 0
        bus_write(32'h04, 32'h0000_0004);
        sw = 16'h0004;
        ticks(10);
        bus_read(32'h08, rdata);
        check("p5_pend", rdata, 32'h0000_0005);
        check("p5_int", {31'd0, int_o}, 32'd1);
        bus_write(32'h08, 32'h0000_0004);
        check("w1c2_int", {31'd0, int_o}, 32'd0);
        bus_read(32'h08, rdata);
        check("w1c2_pend", rdata, 32'h0000_0001);
        bus_write(32'h04, 32'h0000_0001);
        check("remask_int", {31'd0, int_o}, 32'd1);

        // Debounce event on bit 3 coincides with int_rst_i (fires at edge 6)
        sw = 16'h000C;
        ticks(6);                                  // edges 0..5
        int_rst = 1'b1;
        tick();                                    // edge 6
        int_rst = 1'b0;
        bus_read(32'h08, rdata);
        check("same_pend", rdata, 32'h0000_0008);
        bus_read(32'h00, rdata);
        check("same_value", rdata, 32'h0000_000C);
        check("same_int", {31'd0, int_o}, 32'd0);
        tick();
        check("rd_hold", bus_if.RD_o, 32'h0000_000C);

        // Unmapped address
        bus_read(32'h10, rdata);
        check("unmap_rd", rdata, 32'd0);
        bus_write(32'h10, 32'hFFFF_FFFF);
        bus_read(32'h04, rdata);
        check("unmap_mask", rdata, 32'h0000_0001);
        bus_read(32'h0C, rdata);
        check("unmap_thr", rdata, 32'd3);
        bus_read(32'h08, rdata);
        check("unmap_pend", rdata, 32'h0000_0008);

        // Asynchronous reset mid-debounce
        bus_write(32'h04, 32'h0000_0008);
        check("pre_rst_int", {31'd0, int_o}, 32'd1);
        bus_read(32'h0C, rdata);
        sw = 16'h0000;
        ticks(3);
        rst_n = 1'b0;
        #1;
        check("arst_rd", bus_if.RD_o, 32'd0);
        check("arst_int", {31'd0, int_o}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        bus_read(32'h0C, rdata);
        check("arst_thr", rdata, 32'd1000);
        bus_read(32'h00, rdata);
        check("arst_value", rdata, 32'd0);

        // THR=0 gives a 3-cycle latency
        bus_write(32'h0C, 32'd0);
        bus_write(32'h04, 32'h0000_0002);
        sw = 16'h0002;
        ticks(3);                                  // edges 0..2
        check("thr0_e2", {31'd0, int_o}, 32'd0);
        tick();                                    // edge 3
        check("thr0_e3", {31'd0, int_o}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
